pcie_rx_cmd_arb: RTL and testbench
==================================

Name: pcie_rx_cmd_arb

Overview:
Round-robin arbiter that shares the single PCIe RX DMA command FIFO write port among P_NUM_REQ requesters (e.g. NVMe SQ fetch, PRP list fetch, host-write data DMA). It sits in the pcie_user_clk domain, directly upstream of the RX DMA command input (pcie_rx_cmd_wr_en / wr_data / full_n). It enforces a per-requester outstanding-command limit, tracked by completion pulses from the requesters, so no single requester can monopolise RX tags or buffer space.

Parameters:
P_NUM_REQ, 4, number of requesters; fixed at 4 (2-bit source ID).
P_CMD_WIDTH, 46, width of one RX DMA command word; opaque to this block.
P_MAX_OUTSTANDING, 4, maximum accepted-but-not-done commands per requester; legal range 1..15.

Ports:
pcie_user_clk  input  1  clock; all logic on rising edge.
pcie_user_rst_n  input  1  reset, synchronous, active-low.
req_valid  input  4  per-requester command-pending flag; held high until acked.
req_data  input  4*46  command words; requester i occupies bits [46*i+45:46*i]; stable while req_valid[i] is high.
req_ack  output  4  one-cycle pulse; command of requester i accepted.
cmd_done  input  4  one-cycle pulse per requester; one of its commands has fully completed.
pcie_rx_cmd_wr_en  output  1  write strobe to RX DMA command FIFO.
pcie_rx_cmd_wr_data  output  46  command word written.
pcie_rx_cmd_wr_src  output  2  requester index of the current write; meaningful only while wr_en is high.
pcie_rx_cmd_full_n  input  1  RX command FIFO not full.
outstanding_cnt  output  4*4  per-requester outstanding count; requester i at bits [4*i+3:4*i].
done_underflow_err  output  1  sticky; set when cmd_done arrives for a requester whose count is 0.

Behaviour:
- Reset (pcie_user_rst_n low at a clock edge): state=S_IDLE, last_grant=3 (so requester 0 has first priority), all counters 0, req_ack=0, wr_en=0, wr_data=0, wr_src=0, done_underflow_err=0. Reset mid-write drops the in-flight write: wr_en is low on the cycle after the reset edge, and no ack is issued.
- eligible[i] = req_valid[i] & (count[i] < P_MAX_OUTSTANDING).
- FSM:
  - S_IDLE: if pcie_rx_cmd_full_n=1 and any eligible bit is set, pick the first eligible index searching from last_grant+1 mod 4 upward with wrap. Register data/src, set wr_en=1 and req_ack[g]=1 for the next cycle, set last_grant=g, go to S_WR.
  - S_WR: wr_en and ack are high for exactly this one cycle; go to S_GAP.
  - S_GAP: one idle cycle so the registered full_n reflects the write; go to S_IDLE.
- Throughput is at most 1 command per 3 cycles. Latency from req_valid rise with an idle arbiter to wr_en/ack is 1 cycle.
- If full_n=0 in S_IDLE, no grant is made and last_grant is unchanged. full_n is sampled only in S_IDLE; a write in S_WR is never cancelled.
- Counters:
  - Grant in S_IDLE: count[g] += 1, effective in the same cycle wr_en rises.
  - cmd_done[i] with count[i]>0: count[i] -= 1.
  - Grant and done for the same i in the same cycle: count unchanged.
  - cmd_done[i] with count[i]=0 and no simultaneous grant: count stays 0 and done_underflow_err is set. It clears only on reset.
  - Multiple cmd_done bits in one cycle are each handled independently.
- Requester at its limit: it is skipped by the scan and keeps req_valid high. It becomes eligible the cycle after the done pulse that lowers its count.
- req_ack is one-hot or zero; never more than one bit high.

Test Plan:
1. Reset, then req_valid=4'b0001 with data 46'h1234: the next cycle shows wr_en=1, wr_data=46'h1234, wr_src=0, req_ack=4'b0001, outstanding_cnt[0]=1.
2. All four requesters valid continuously, full_n=1, cmd_done pulsed after each ack: grant order 0,1,2,3,0,1, with wr_en pulses exactly 3 cycles apart.
3. Only requester 2 valid, no cmd_done, P_MAX_OUTSTANDING=4: exactly 4 acks, then no wr_en; one cmd_done[2] yields a 5th ack, and count returns to 4.
4. full_n=0 for 10 cycles with requesters 1 and 3 valid: no wr_en and no ack. Raise full_n: requester 1 is granted first (last_grant=3 after reset), then requester 3.
5. Grant to requester 0 and cmd_done[0] in the same cycle with count 2: count stays 2. Then cmd_done[1] with count[1]=0: done_underflow_err=1 and count[1]=0.
6. Assert reset in the S_WR cycle: the following cycle has wr_en=0, req_ack=0, all counts 0, state S_IDLE, and the next grant goes to requester 0.

Source files
------------

// File: rtl/pcie_rx_cmd_arb_if.sv
// ---------------------------------------------------------------------------
// pcie_rx_cmd_arb_if
// Bundles the requester-side command handshake and the RX DMA command FIFO
// write port that pcie_rx_cmd_arb sits between.
//
// Signals:
//   req_valid            per-requester command pending, held until acked
//   req_data             packed command words, requester i at [W*i +: W]
//   req_ack              one-cycle accept pulse, one-hot or zero
//   cmd_done             one-cycle completion pulse per requester
//   pcie_rx_cmd_wr_en    write strobe into the RX DMA command FIFO
//   pcie_rx_cmd_wr_data  command word being written
//   pcie_rx_cmd_wr_src   requester index of the current write
//   pcie_rx_cmd_full_n   FIFO not full
//
// Modports:
//   master  the arbiter (drives acks and the FIFO write port)
//   slave   the environment (requesters plus the FIFO)
// ---------------------------------------------------------------------------
interface pcie_rx_cmd_arb_if #(
  parameter int P_NUM_REQ   = 4,
  parameter int P_CMD_WIDTH = 46,
  parameter int P_SRC_WIDTH = 2
);
  logic [P_NUM_REQ-1:0]             req_valid;
  logic [P_NUM_REQ*P_CMD_WIDTH-1:0] req_data;
  logic [P_NUM_REQ-1:0]             req_ack;
  logic [P_NUM_REQ-1:0]             cmd_done;
  logic                             pcie_rx_cmd_wr_en;
  logic [P_CMD_WIDTH-1:0]           pcie_rx_cmd_wr_data;
  logic [P_SRC_WIDTH-1:0]           pcie_rx_cmd_wr_src;
  logic                             pcie_rx_cmd_full_n;

  modport master (
    input  req_valid,
    input  req_data,
    input  cmd_done,
    input  pcie_rx_cmd_full_n,
    output req_ack,
    output pcie_rx_cmd_wr_en,
    output pcie_rx_cmd_wr_data,
    output pcie_rx_cmd_wr_src
  );

  modport slave (
    output req_valid,
    output req_data,
    output cmd_done,
    output pcie_rx_cmd_full_n,
    input  req_ack,
    input  pcie_rx_cmd_wr_en,
    input  pcie_rx_cmd_wr_data,
    input  pcie_rx_cmd_wr_src
  );
endinterface

// File: rtl/pcie_rx_cmd_arb.sv
// ---------------------------------------------------------------------------
// pcie_rx_cmd_arb
// Round-robin arbiter sharing the single RX DMA command FIFO write port among
// P_NUM_REQ requesters in the pcie_user_clk domain. Each requester may have at
// most P_MAX_OUTSTANDING accepted-but-not-completed commands; completion is
// reported back through cmd_done pulses. One command is issued at most every
// three cycles (IDLE -> WR -> GAP) so full_n always reflects the last write
// before the next grant decision.
//
// Ports:
//   pcie_user_clk       clock, rising edge
//   pcie_user_rst_n     synchronous active-low reset
//   bus                 requester handshake + FIFO write port (master modport)
//   outstanding_cnt     per-requester outstanding count, requester i at [4*i +: 4]
//   done_underflow_err  sticky, cmd_done seen for a requester with count 0
// ---------------------------------------------------------------------------
module pcie_rx_cmd_arb #(
  parameter int P_NUM_REQ         = 4,
  parameter int P_CMD_WIDTH       = 46,
  parameter int P_MAX_OUTSTANDING = 4
) (
  input  logic                     pcie_user_clk,
  input  logic                     pcie_user_rst_n,
  pcie_rx_cmd_arb_if.master        bus,
  output logic [4*P_NUM_REQ-1:0]   outstanding_cnt,
  output logic                     done_underflow_err
);

  localparam int ID_W = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ID_W-1:0]       last_grant;
  logic [ID_W-1:0]       grant_idx;
  logic [ID_W-1:0]       cand;
  logic                  any_eligible;
  logic                  do_grant;
  logic [P_NUM_REQ-1:0]  eligible;
  logic [P_NUM_REQ-1:0]  grant_vec;
  logic [3:0]            count [P_NUM_REQ];

  // A requester at its outstanding limit is simply invisible to the scan.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < P_NUM_REQ; i++) begin
      eligible[i] = bus.req_valid[i] && (count[i] < 4'(P_MAX_OUTSTANDING));
    end
  end

  // Scan starts one past the last winner and wraps, so the last winner is
  // checked last; the first hit wins.
  always_comb begin
    grant_idx    = last_grant;
    any_eligible = 1'b0;
    cand         = '0;
    for (int k = 1; k <= P_NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant) + k) % P_NUM_REQ);
      if (!any_eligible && eligible[cand]) begin
        grant_idx    = cand;
        any_eligible = 1'b1;
      end
    end
  end

  always_ff @(posedge pcie_user_clk) begin
    if (!pcie_user_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // full_n is only consulted in IDLE; once granted, the write always goes out.
  always_comb begin
    state_next = state;
    do_grant   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.pcie_rx_cmd_full_n && any_eligible) begin
          do_grant   = 1'b1;
          state_next = S_WR;
        end
      end
      S_WR:    state_next = S_GAP;
      S_GAP:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    grant_vec = '0;
    if (do_grant) begin
      grant_vec = P_NUM_REQ'(1) << grant_idx;
    end
  end

  // Write port and ack are registered from the grant decision, so they are
  // high exactly during the WR cycle. last_grant resets to the top index so
  // requester 0 gets first priority.
  always_ff @(posedge pcie_user_clk) begin
    if (!pcie_user_rst_n) begin
      bus.pcie_rx_cmd_wr_en   <= 1'b0;
      bus.pcie_rx_cmd_wr_data <= '0;
      bus.pcie_rx_cmd_wr_src  <= '0;
      bus.req_ack             <= '0;
      last_grant              <= ID_W'(P_NUM_REQ - 1);
    end else begin
      bus.pcie_rx_cmd_wr_en <= do_grant;
      bus.req_ack           <= grant_vec;
      if (do_grant) begin
        bus.pcie_rx_cmd_wr_data <= bus.req_data[grant_idx*P_CMD_WIDTH +: P_CMD_WIDTH];
        bus.pcie_rx_cmd_wr_src  <= grant_idx;
        last_grant              <= grant_idx;
      end
    end
  end

  // A grant and a done for the same requester in one cycle cancel out. A done
  // against a zero count is dropped and latched as an error.
  always_ff @(posedge pcie_user_clk) begin
    if (!pcie_user_rst_n) begin
      for (int i = 0; i < P_NUM_REQ; i++) begin
        count[i] <= '0;
      end
      done_underflow_err <= 1'b0;
    end else begin
      for (int i = 0; i < P_NUM_REQ; i++) begin
        if (grant_vec[i] && !bus.cmd_done[i]) begin
          count[i] <= count[i] + 4'd1;
        end else if (!grant_vec[i] && bus.cmd_done[i]) begin
          if (count[i] != 4'd0) begin
            count[i] <= count[i] - 4'd1;
          end else begin
            done_underflow_err <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    outstanding_cnt = '0;
    for (int i = 0; i < P_NUM_REQ; i++) begin
      outstanding_cnt[4*i +: 4] = count[i];
    end
  end

endmodule

// File: tb/tb_pcie_rx_cmd_arb.sv
// ---------------------------------------------------------------------------
// tb_pcie_rx_cmd_arb
// Self-checking bench for pcie_rx_cmd_arb. Expected writes (source, data) are
// queued as stimulus is applied and popped whenever the arbiter writes; each
// scenario task also checks counts, timing and flags directly.
// ---------------------------------------------------------------------------
module tb_pcie_rx_cmd_arb;

  localparam int NR = 4;
  localparam int CW = 46;

  typedef struct packed {
    logic [1:0]    src;
    logic [CW-1:0] data;
  } exp_t;

  logic          pcie_user_clk = 1'b0;
  logic          pcie_user_rst_n = 1'b0;
  logic [4*NR-1:0] outstanding_cnt;
  logic          done_underflow_err;

  exp_t          sb [$];
  logic [CW-1:0] d [NR];
  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  bit            mon_en = 1'b0;

  pcie_rx_cmd_arb_if #(.P_NUM_REQ(NR), .P_CMD_WIDTH(CW), .P_SRC_WIDTH(2)) bus ();

  pcie_rx_cmd_arb #(
    .P_NUM_REQ(NR),
    .P_CMD_WIDTH(CW),
    .P_MAX_OUTSTANDING(4)
  ) dut (
    .pcie_user_clk(pcie_user_clk),
    .pcie_user_rst_n(pcie_user_rst_n),
    .bus(bus),
    .outstanding_cnt(outstanding_cnt),
    .done_underflow_err(done_underflow_err)
  );

  always #5 pcie_user_clk = ~pcie_user_clk;

  always @(posedge pcie_user_clk) cyc <= cyc + 1;

  // Advance one cycle and sample 1 time unit after the edge. Every sampled
  // write is matched against the head of the expectation queue.
  task automatic tick;
    exp_t       e;
    logic [3:0] exp_ack;
    @(posedge pcie_user_clk);
    #1;
    if (mon_en) begin
      n_checks++;
      if (bus.pcie_rx_cmd_wr_en === 1'b1) begin
        if (sb.size() == 0) begin
          $display("[TB] FAIL sb_unexpected: wr_en=1 src=%0d data=%h, required no write",
                   bus.pcie_rx_cmd_wr_src, bus.pcie_rx_cmd_wr_data);
          n_fail++;
        end else begin
          e = sb.pop_front();
          exp_ack = 4'b0001 << e.src;
          if (bus.pcie_rx_cmd_wr_src !== e.src || bus.pcie_rx_cmd_wr_data !== e.data ||
              bus.req_ack !== exp_ack) begin
            $display("[TB] FAIL sb_write: src=%0d data=%h ack=%b, required src=%0d data=%h ack=%b",
                     bus.pcie_rx_cmd_wr_src, bus.pcie_rx_cmd_wr_data, bus.req_ack,
                     e.src, e.data, exp_ack);
            n_fail++;
          end
        end
      end else if (bus.req_ack !== 4'b0000) begin
        $display("[TB] FAIL sb_ack_idle: ack=%b wr_en=%b, required ack=0000",
                 bus.req_ack, bus.pcie_rx_cmd_wr_en);
        n_fail++;
      end
    end
  endtask

  task automatic push(input int s);
    sb.push_back({2'(s), d[s]});
  endtask

  task automatic wait_wr(input int budget, output int waited);
    waited = 0;
    while (bus.pcie_rx_cmd_wr_en !== 1'b1 && waited < budget) begin
      tick();
      waited++;
    end
    if (bus.pcie_rx_cmd_wr_en !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL wait_wr: wr_en=%b after %0d cycles, required 1",
               bus.pcie_rx_cmd_wr_en, budget);
    end
  endtask

  task automatic reset_dut;
    pcie_user_rst_n = 1'b0;
    bus.req_valid = '0;
    bus.cmd_done = '0;
    bus.pcie_rx_cmd_full_n = 1'b1;
    tick();
    tick();
    pcie_user_rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset;
    reset_dut();
    n_checks++;
    if (bus.pcie_rx_cmd_wr_en !== 1'b0 || bus.req_ack !== 4'b0000) begin
      $display("[TB] FAIL reset_strobes: wr_en=%b ack=%b, required 0 0000",
               bus.pcie_rx_cmd_wr_en, bus.req_ack);
      n_fail++;
    end
    n_checks++;
    if (bus.pcie_rx_cmd_wr_data !== 46'h0 || bus.pcie_rx_cmd_wr_src !== 2'd0) begin
      $display("[TB] FAIL reset_bus: data=%h src=%0d, required 0 0",
               bus.pcie_rx_cmd_wr_data, bus.pcie_rx_cmd_wr_src);
      n_fail++;
    end
    n_checks++;
    if (outstanding_cnt !== 16'h0 || done_underflow_err !== 1'b0) begin
      $display("[TB] FAIL reset_counts: cnt=%h err=%b, required 0000 0",
               outstanding_cnt, done_underflow_err);
      n_fail++;
    end
  endtask

  task automatic test_single;
    reset_dut();
    bus.req_valid = 4'b0001;
    push(0);
    tick();
    n_checks++;
    if (bus.pcie_rx_cmd_wr_en !== 1'b1 || bus.pcie_rx_cmd_wr_data !== 46'h1234 ||
        bus.pcie_rx_cmd_wr_src !== 2'd0 || bus.req_ack !== 4'b0001) begin
      $display("[TB] FAIL single_latency: wr_en=%b data=%h src=%0d ack=%b, required 1 1234 0 0001",
               bus.pcie_rx_cmd_wr_en, bus.pcie_rx_cmd_wr_data, bus.pcie_rx_cmd_wr_src, bus.req_ack);
      n_fail++;
    end
    n_checks++;
    if (outstanding_cnt[3:0] !== 4'd1) begin
      $display("[TB] FAIL single_count: cnt0=%0d, required 1", outstanding_cnt[3:0]);
      n_fail++;
    end
    bus.req_valid = 4'b0000;
    tick();
    bus.cmd_done = 4'b0001;
    tick();
    bus.cmd_done = 4'b0000;
    n_checks++;
    if (outstanding_cnt[3:0] !== 4'd0) begin
      $display("[TB] FAIL single_done: cnt0=%0d, required 0", outstanding_cnt[3:0]);
      n_fail++;
    end
  endtask

  task automatic test_round_robin;
    int w;
    int last;
    reset_dut();
    bus.req_valid = 4'b1111;
    for (int g = 0; g < 6; g++) push(g % 4);
    last = 0;
    for (int g = 0; g < 6; g++) begin
      wait_wr(8, w);
      if (g > 0) begin
        n_checks++;
        if (cyc - last !== 3) begin
          $display("[TB] FAIL rr_spacing: grant %0d came %0d cycles after previous, required 3",
                   g, cyc - last);
          n_fail++;
        end
      end
      last = cyc;
      bus.cmd_done = 4'b0001 << (g % 4);
      tick();
      bus.cmd_done = 4'b0000;
    end
    bus.req_valid = 4'b0000;
    repeat (3) tick();
    n_checks++;
    if (sb.size() !== 0 || outstanding_cnt !== 16'h0) begin
      $display("[TB] FAIL rr_drain: pending=%0d cnt=%h, required 0 0000", sb.size(), outstanding_cnt);
      n_fail++;
    end
  endtask

  task automatic test_limit;
    int w;
    int hits;
    reset_dut();
    bus.req_valid = 4'b0100;
    for (int g = 0; g < 4; g++) begin
      push(2);
      wait_wr(8, w);
      tick();
    end
    hits = 0;
    repeat (12) begin
      tick();
      if (bus.pcie_rx_cmd_wr_en !== 1'b0) hits++;
    end
    n_checks++;
    if (hits !== 0 || outstanding_cnt[11:8] !== 4'd4) begin
      $display("[TB] FAIL limit_block: extra writes=%0d cnt2=%0d, required 0 4",
               hits, outstanding_cnt[11:8]);
      n_fail++;
    end
    push(2);
    bus.cmd_done = 4'b0100;
    tick();
    bus.cmd_done = 4'b0000;
    wait_wr(4, w);
    n_checks++;
    if (w !== 1 || outstanding_cnt[11:8] !== 4'd4) begin
      $display("[TB] FAIL limit_release: latency=%0d cnt2=%0d, required 1 4",
               w, outstanding_cnt[11:8]);
      n_fail++;
    end
    bus.req_valid = 4'b0000;
    tick();
    n_checks++;
    if (sb.size() !== 0) begin
      $display("[TB] FAIL limit_pending: pending=%0d, required 0", sb.size());
      n_fail++;
    end
  endtask

  task automatic test_backpressure;
    int w;
    int hits;
    reset_dut();
    bus.pcie_rx_cmd_full_n = 1'b0;
    bus.req_valid = 4'b1010;
    hits = 0;
    repeat (10) begin
      tick();
      if (bus.pcie_rx_cmd_wr_en !== 1'b0 || bus.req_ack !== 4'b0000) hits++;
    end
    n_checks++;
    if (hits !== 0) begin
      $display("[TB] FAIL full_hold: active cycles=%0d, required 0", hits);
      n_fail++;
    end
    push(1);
    push(3);
    bus.pcie_rx_cmd_full_n = 1'b1;
    wait_wr(4, w);
    bus.req_valid = 4'b1000;
    tick();
    wait_wr(6, w);
    bus.req_valid = 4'b0000;
    tick();
    n_checks++;
    if (sb.size() !== 0 || outstanding_cnt !== 16'h1010) begin
      $display("[TB] FAIL full_release: pending=%0d cnt=%h, required 0 1010",
               sb.size(), outstanding_cnt);
      n_fail++;
    end
  endtask

  task automatic test_done_collision;
    int w;
    reset_dut();
    bus.req_valid = 4'b0001;
    push(0);
    push(0);
    push(0);
    wait_wr(4, w);
    tick();
    wait_wr(6, w);
    tick();
    tick();
    n_checks++;
    if (outstanding_cnt[3:0] !== 4'd2 || bus.pcie_rx_cmd_wr_en !== 1'b0) begin
      $display("[TB] FAIL coll_setup: cnt0=%0d wr_en=%b, required 2 0",
               outstanding_cnt[3:0], bus.pcie_rx_cmd_wr_en);
      n_fail++;
    end
    bus.cmd_done = 4'b0001;
    tick();
    bus.cmd_done = 4'b0000;
    n_checks++;
    if (bus.pcie_rx_cmd_wr_en !== 1'b1 || outstanding_cnt[3:0] !== 4'd2) begin
      $display("[TB] FAIL coll_same_cycle: wr_en=%b cnt0=%0d, required 1 2",
               bus.pcie_rx_cmd_wr_en, outstanding_cnt[3:0]);
      n_fail++;
    end
    bus.req_valid = 4'b0000;
    tick();
    n_checks++;
    if (done_underflow_err !== 1'b0) begin
      $display("[TB] FAIL coll_no_err: err=%b, required 0", done_underflow_err);
      n_fail++;
    end
    bus.cmd_done = 4'b0010;
    tick();
    bus.cmd_done = 4'b0000;
    n_checks++;
    if (done_underflow_err !== 1'b1 || outstanding_cnt[7:4] !== 4'd0) begin
      $display("[TB] FAIL underflow: err=%b cnt1=%0d, required 1 0",
               done_underflow_err, outstanding_cnt[7:4]);
      n_fail++;
    end
    repeat (3) tick();
    n_checks++;
    if (done_underflow_err !== 1'b1 || sb.size() !== 0) begin
      $display("[TB] FAIL underflow_sticky: err=%b pending=%0d, required 1 0",
               done_underflow_err, sb.size());
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_write;
    int w;
    reset_dut();
    bus.req_valid = 4'b0010;
    push(1);
    wait_wr(4, w);
    pcie_user_rst_n = 1'b0;
    tick();
    n_checks++;
    if (bus.pcie_rx_cmd_wr_en !== 1'b0 || bus.req_ack !== 4'b0000 || outstanding_cnt !== 16'h0) begin
      $display("[TB] FAIL rst_mid_write: wr_en=%b ack=%b cnt=%h, required 0 0000 0000",
               bus.pcie_rx_cmd_wr_en, bus.req_ack, outstanding_cnt);
      n_fail++;
    end
    pcie_user_rst_n = 1'b1;
    bus.req_valid = 4'b1011;
    push(0);
    tick();
    n_checks++;
    if (bus.pcie_rx_cmd_wr_en !== 1'b1 || bus.pcie_rx_cmd_wr_src !== 2'd0) begin
      $display("[TB] FAIL rst_next_grant: wr_en=%b src=%0d, required 1 0",
               bus.pcie_rx_cmd_wr_en, bus.pcie_rx_cmd_wr_src);
      n_fail++;
    end
    bus.req_valid = 4'b0000;
    tick();
    tick();
    n_checks++;
    if (sb.size() !== 0) begin
      $display("[TB] FAIL rst_pending: pending=%0d, required 0", sb.size());
      n_fail++;
    end
  endtask

  initial begin
    d[0] = 46'h0000_0000_1234;
    d[1] = 46'h2AAA_BBBB_0001;
    d[2] = 46'h1555_4444_0002;
    d[3] = 46'h3FFF_0000_FFF3;
    bus.req_data = {d[3], d[2], d[1], d[0]};
    bus.req_valid = '0;
    bus.cmd_done = '0;
    bus.pcie_rx_cmd_full_n = 1'b1;
    test_reset();
    mon_en = 1'b1;
    test_single();
    test_round_robin();
    test_limit();
    test_backpressure();
    test_done_collision();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
